pipelined_adder: RTL and testbench

//  Parametrised, pipelined WIDTH-bit adder/subtractor with valid/ready flow control.

---
 rtl/pipelined_adder.sv | 131 +++++++++++++
 tb/tb_pipelined_adder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready flow control; STAGES slices, one carry register per slice boundary.
// Optional signed output saturation is enabled by defining PIPELINED_ADDER_SAT_EN.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = (STAGES >= 1) ? WIDTH / STAGES : WIDTH;

    if (STAGES < 1) begin : g_bad_stages
        $error("pipelined_adder: STAGES must be at least 1");
    end else if (WIDTH % STAGES != 0) begin : g_bad_width
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

`ifdef PIPELINED_ADDER_SAT_EN
    function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] raw,
                                                  input logic             ovf_f,
                                                  input logic             neg);
        logic signed [WIDTH-1:0] smin;
        logic signed [WIDTH-1:0] smax;
        smin = {1'b1, {(WIDTH-1){1'b0}}};
        smax = ~smin;
        if (!ovf_f) begin
            return raw;
        end
        return neg ? smin : smax;
    endfunction
`endif

    // One global advance: the whole pipe moves unless a result is blocked at the output.
    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign b_eff    = sub ? ~b : b;
    assign cin_eff  = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             v_src;
        logic [SW:0]      slice_sum;
        logic [WIDTH-1:0] s_d;
        logic [WIDTH-1:0] s_fin;
        logic             ovf_d;
        logic [WIDTH-1:0] a_q;
        logic [WIDTH-1:0] b_q;
        logic [WIDTH-1:0] s_q;
        logic             c_q;
        logic             v_q;
        logic             ovf_q;

        if (k == 0) begin : g_head
            assign a_src = a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = cin_eff;
            assign v_src = in_valid;
        end else begin : g_body
            assign a_src = g_stg[k-1].a_q;
            assign b_src = g_stg[k-1].b_q;
            assign s_src = g_stg[k-1].s_q;
            assign c_src = g_stg[k-1].c_q;
            assign v_src = g_stg[k-1].v_q;
        end

        assign slice_sum = {1'b0, a_src[k*SW +: SW]} + {1'b0, b_src[k*SW +: SW]}
                         + {{SW{1'b0}}, c_src};

        always_comb begin
            s_d = s_src;
            s_d[k*SW +: SW] = slice_sum[SW-1:0];
        end

        // Overflow uses the raw sum; saturation only ever touches the final register.
        if (k == STAGES - 1) begin : g_tail
            assign ovf_d = (a_src[WIDTH-1] == b_src[WIDTH-1]) & (s_d[WIDTH-1] != a_src[WIDTH-1]);
`ifdef PIPELINED_ADDER_SAT_EN
            assign s_fin = saturate(s_d, ovf_d, a_src[WIDTH-1]);
`else
            assign s_fin = s_d;
`endif
        end else begin : g_mid
            assign ovf_d = 1'b0;
            assign s_fin = s_d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                ovf_q <= 1'b0;
                a_q   <= '0;
                b_q   <= '0;
                s_q   <= '0;
            end else if (adv) begin
                v_q   <= v_src;
                c_q   <= slice_sum[SW];
                ovf_q <= ovf_d;
                a_q   <= a_src;
                b_q   <= b_src;
                s_q   <= s_fin;
            end
        end
    end

    assign out_valid = g_stg[STAGES-1].v_q;
    assign sum       = g_stg[STAGES-1].s_q;
    assign cout      = g_stg[STAGES-1].c_q;
    assign ovf       = g_stg[STAGES-1].ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed-vector and scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4).
module tb_pipelined_adder;
    localparam int W    = 32;
    localparam int S    = 4;
    localparam int NVEC = 10;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] s;
        logic         co;
        logic         ov;
    } vec_t;

`ifdef PIPELINED_ADDER_SAT_EN
    localparam logic [W-1:0] EXP_SUB_OVF = 32'h8000_0000;
    localparam logic [W-1:0] EXP_ADD_POS = 32'h7FFF_FFFF;
    localparam logic [W-1:0] EXP_ADD_NEG = 32'h8000_0000;
`else
    localparam logic [W-1:0] EXP_SUB_OVF = 32'h7FFF_FFFF;
    localparam logic [W-1:0] EXP_ADD_POS = 32'h8000_0000;
    localparam logic [W-1:0] EXP_ADD_NEG = 32'h0000_0000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     checks = 0;
    int     errors = 0;
    vec_t   vecs [NVEC];
    vec_t   cur;
    vec_t   sbq [$];
    int     sbc [$];
    logic   strict_lat;
    logic   prev_stall;
    logic [W-1:0] prev_sum;
    logic   prev_co;
    logic   prev_ov;
    logic   last_in;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, want 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                   input logic fcin, input logic fsub);
        vec_t   v;
        longint sa, sb, r, hi, lo;
        logic [W:0] t;
        sa = longint'($signed(fa));
        sb = longint'($signed(fb));
        hi = (longint'(1) <<< (W-1)) - 1;
        lo = -hi - 1;
        v.a = fa; v.b = fb; v.cin = fcin; v.sub = fsub;
        if (fsub) begin
            r    = sa - sb;
            v.s  = fa - fb;
            v.co = (fa >= fb);
        end else begin
            r    = sa + sb + longint'(fcin);
            t    = {1'b0, fa} + {1'b0, fb} + {{W{1'b0}}, fcin};
            v.s  = t[W-1:0];
            v.co = t[W];
        end
        v.ov = (r > hi) || (r < lo);
`ifdef PIPELINED_ADDER_SAT_EN
        if (v.ov) v.s = (r < 0) ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return v;
    endfunction

    function automatic vec_t rand_vec();
        return model($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    task automatic drive(input vec_t v);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        cur = v;
        in_valid = 1'b1;
    endtask

    // One cycle: sample just after the falling edge, score transfers, then wait for the next falling edge.
    task automatic tick();
        vec_t e;
        int   c0;
        logic exp_rdy;
        logic lat_ok;
        #1;
        exp_rdy = ~out_valid | out_ready;
        check("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            check("hold_sum", sum, prev_sum);
            check("hold_cout", cout, prev_co);
            check("hold_ovf", ovf, prev_ov);
        end
        if (out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got sum 0x%h, want no beat (cycle %0d)", sum, cyc);
            end else begin
                e  = sbq.pop_front();
                c0 = sbc.pop_front();
                check("sum", sum, e.s);
                check("cout", cout, e.co);
                check("ovf", ovf, e.ov);
                if (strict_lat) begin
                    check("latency", cyc - c0, S);
                end else begin
                    lat_ok = (cyc - c0 >= S);
                    check("latency_min", lat_ok, 1'b1);
                end
            end
        end
        prev_stall = out_valid & ~out_ready;
        prev_sum   = sum;
        prev_co    = cout;
        prev_ov    = ovf;
        last_in    = in_valid & in_ready;
        if (last_in) begin
            sbq.push_back(cur);
            sbc.push_back(cyc);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && sbq.size() > 0; t++) tick();
        check("drain", sbq.size(), 0);
    endtask

    initial begin
        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, EXP_SUB_OVF, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, EXP_ADD_POS, 1'b0, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, EXP_ADD_NEG, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0007, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{32'h0000_0010, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_000D, 1'b1, 1'b0};
        vecs[8] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vecs[9] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0100_0000, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        strict_lat = 1'b1; prev_stall = 1'b0; last_in = 1'b0;
        prev_sum = '0; prev_co = 1'b0; prev_ov = 1'b0;
        cur = vecs[0];

        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_sum", sum, '0);
        check("rst_cout", cout, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single beats, each drained before the next.
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i]);
            tick();
            in_valid = 1'b0;
            drain();
        end

        // Back-to-back beats at full throughput.
        for (int i = 0; i < 100; i++) begin
            drive(rand_vec());
            tick();
        end
        drain();

        // Random output back-pressure and input gaps.
        strict_lat = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!in_valid || last_in) begin
                if ($urandom_range(0, 3) != 0) drive(rand_vec());
                else in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain();

        // Reset with three beats in flight, one already presented at the output.
        strict_lat = 1'b1;
        out_ready  = 1'b1;
        drive(model(32'h0000_0005, 32'h0000_0009, 1'b0, 1'b0)); tick();
        drive(model(32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0)); tick();
        drive(model(32'h0000_0030, 32'h0000_0010, 1'b0, 1'b1)); tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        #1;
        check("pre_rst_out_valid", out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_sum", sum, '0);
        check("midrst_cout", cout, 1'b0);
        sbq.delete();
        sbc.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        #1;
        check("inrst_out_valid", out_valid, 1'b0);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 10; t++) begin
            #1;
            check("no_stale", out_valid, 1'b0);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
